aes_spi_responder: RTL and testbench
====================================

Name: aes_spi_responder

Overview:
- Command-level SPI responder: the external-facing slave end of the clock-synchronous bit-serial link that the AES SPI master drives.
- Lets an off-chip master load a key, run encrypt or decrypt, and read the result back.
- Sequences KeyExpansion, Cipher and Decipher through their reset-held start lines.
- Sits between the chip pins and the three AES cores; replaces the master-side sequencer when the host is external.

Parameters:
- BLOCK_W, 128, data block width in bits.
- KEY_W, 256, maximum key width; shorter keys are left-aligned and zero-filled below.
- OP_W, 8, opcode width.

Ports:
- clk  in  1  system clock; all link bits sampled/driven on its rising edge.
- reset  in  1  synchronous, active-high.
- cs  in  1  chip select, active-high; frame spans one contiguous cs-high interval.
- mosi  in  1  serial in, MSB first, one bit per clk while cs=1.
- miso  out  1  serial out, MSB first.
- key_out  out  KEY_W  key to KeyExpansion.
- Nk_out  out  8  4, 6 or 8.
- data_out  out  BLOCK_W  block to Cipher/Decipher.
- result_in  in  BLOCK_W  output of the running core.
- keyExpansionDone, encryptionDone, decryptionDone  in  1 each  core done levels.
- resetKeyExpansion, resetCipher, resetDecipher  out  1 each  core holds; 1 = held, 0 = run.
- busy  out  1  a core is running.

Behaviour:
- Reset values:
  - miso=0, busy=0.
  - key_out, data_out = 0; Nk_out=4.
  - All three core resets = 1.
  - key_valid=0, result_valid=0, err=0.
- FSM states: IDLE, OPCODE, PAYLOAD, DRAIN, RUN, RESPOND.
- IDLE -> OPCODE on first clk with cs=1; that cycle's mosi is opcode bit 7.
- OPCODE: 8 bits shifted. Decode:
  - 0x14/0x16/0x18: LOAD_KEY, Nk=4/6/8, payload Nk*32 bits.
  - 0x20: ENCRYPT, 128 bits.
  - 0x30: DECRYPT, 128 bits.
  - 0x40: READ, no payload.
  - Any other value: set err, go DRAIN.
- PAYLOAD: bit counter counts to payload length; shift register captures MSB first.
- Cycle after last payload bit:
  - Load key_out (left-aligned) and Nk_out, or data_out.
  - Drop the selected core reset to 0; busy=1; state RUN.
- RUN: on first cycle the selected done=1:
  - ENCRYPT/DECRYPT: capture result_in into the result register, result_valid=1.
  - LOAD_KEY: key_valid=1.
  - Next cycle: core reset back to 1, busy=0, IDLE (or DRAIN if cs still high).
- READ:
  - RESPOND starts on the cycle after opcode bit 0.
  - miso drives result[127] first, one bit per clk, 128 cycles, then 0.
  - If result_valid=0, all 128 bits are 0 and err is set.
  - READ does not clear result_valid.
- Rejections (err set, nothing started, frame drained):
  - ENCRYPT/DECRYPT with key_valid=0.
  - Any command except READ while busy=1.
- cs falling mid-opcode or mid-payload:
  - Abort; discard the shift register; no core started; err set; IDLE next cycle.
- cs falling during RUN: the core keeps running; completion is still captured.
- cs falling during RESPOND: stop shifting, miso=0, IDLE.
- DRAIN: ignore mosi, miso=0, until cs=0, then IDLE.
- Simultaneous done levels: only the done of the started core is observed; others are ignored.
- A new LOAD_KEY:
  - Clears key_valid at its start.
  - Sets key_valid again on keyExpansionDone.
  - Does not touch result_valid.
- err is cleared by a successful READ or by reset.
- Synchronous reset at any point: all outputs go to reset values on the next edge, including mid-RUN; cores are re-held.

Optional Feature:
- Macro: AES_RSP_STATUS_EN.
- Defined:
  - READ response is 128 result bits followed by 8 status bits {busy, key_valid, result_valid, err, Nk_out[3:0]}, MSB first.
  - New opcode 0x50 STATUS returns only those 8 bits.
- Undefined: READ returns 128 bits only; 0x50 decodes as invalid.

Decomposition:
- Package aes_spi_pkg:
  - Opcode constants: OP_KEY128/192/256, OP_ENC, OP_DEC, OP_READ, OP_STATUS.
  - Payload-length constants.
  - FSM state enum.
- Natural sub-module: aes_spi_shifter. Holds the bit counter, 256-bit shift-in register and 128/136-bit shift-out register, with load/shift/clear controls; the FSM and core sequencing stay in the top.

Test Plan:
- LOAD_KEY 0x18 + key 000102…1e1f, then ENCRYPT 00112233445566778899aabbccddeeff, then READ.
  -> resetKeyExpansion low until done; miso streams 8ea2b7ca516745bfeafc49904b496089.
- LOAD_KEY 0x14 + key 000102…0e0f, then DECRYPT 69c4e0d86a7b0430d8cdb78070b4c55a, then READ.
  -> miso streams 00112233445566778899aabbccddeeff; Nk_out=4.
- ENCRYPT after reset with no key -> err=1, resetCipher stays 1, busy=0; next READ returns 128 zero bits.
- cs dropped after 60 of 128 ENCRYPT payload bits -> no core reset toggles, data_out unchanged, err=1, IDLE next cycle.
- Opcode 0x7F, then 200 junk bits -> DRAIN, miso=0 throughout, err=1; valid READ afterwards clears err.
- reset pulsed mid-RUN of Decipher -> next edge: resetDecipher=1, busy=0, result_valid=0, key_valid=0; with AES_RSP_STATUS_EN, STATUS returns 0x04.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - opcodes, payload lengths and FSM state type for the AES SPI responder
package aes_spi_pkg;

  localparam logic [7:0] OP_KEY128 = 8'h14;
  localparam logic [7:0] OP_KEY192 = 8'h16;
  localparam logic [7:0] OP_KEY256 = 8'h18;
  localparam logic [7:0] OP_ENC    = 8'h20;
  localparam logic [7:0] OP_DEC    = 8'h30;
  localparam logic [7:0] OP_READ   = 8'h40;
  localparam logic [7:0] OP_STATUS = 8'h50;

  localparam logic [8:0] LEN_KEY128 = 9'd128;
  localparam logic [8:0] LEN_KEY192 = 9'd192;
  localparam logic [8:0] LEN_KEY256 = 9'd256;
  localparam logic [8:0] LEN_BLOCK  = 9'd128;
  localparam logic [8:0] LEN_STATUS = 9'd8;
`ifdef AES_RSP_STATUS_EN
  localparam logic [8:0] LEN_READ   = 9'd136;
`else
  localparam logic [8:0] LEN_READ   = 9'd128;
`endif

  localparam int OUT_W = 136;

  typedef enum logic [2:0] {IDLE, OPCODE, PAYLOAD, DRAIN, RUN, RESPOND} stateT;
  typedef enum logic [1:0] {CMD_KEY, CMD_ENC, CMD_DEC} cmdT;

  // Keys arrive right-aligned in the shift register; the core wants them MSB-aligned.
  function automatic logic [255:0] leftAlignKey(input logic [255:0] raw, input logic [8:0] len);
    return raw << (9'd256 - len);
  endfunction

endpackage

// File: rtl/aes_spi_shifter.sv
// rtl/aes_spi_shifter.sv - bit counter, serial shift-in and shift-out registers
module aes_spi_shifter
  import aes_spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shiftIn,
  input  logic             inBit,
  input  logic             shiftOut,
  input  logic             loadOut,
  input  logic             clearOut,
  input  logic [OUT_W-1:0] outData,
  output logic [8:0]       count,
  output logic [255:0]     shiftedNow,
  output logic             outBit
);

  // 255 stored bits plus the live input bit form the full 256-bit capture view.
  logic [254:0]     inReg;
  logic [OUT_W-1:0] outReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 9'd0;
      inReg  <= '0;
      outReg <= '0;
    end else begin
      if (clear) begin
        count <= 9'd0;
        inReg <= '0;
      end else begin
        if (shiftIn) inReg <= shiftedNow[254:0];
        if (shiftIn || shiftOut) count <= count + 9'd1;
      end
      if (clearOut)      outReg <= '0;
      else if (loadOut)  outReg <= outData;
      else if (shiftOut) outReg <= {outReg[OUT_W-2:0], 1'b0};
    end
  end

  assign shiftedNow = {inReg, inBit};
  assign outBit     = outReg[OUT_W-1];

endmodule

// File: rtl/aes_spi_responder.sv
// rtl/aes_spi_responder.sv - SPI command responder sequencing KeyExpansion, Cipher and Decipher
// Optional status byte on READ and STATUS opcode: AES_RSP_STATUS_EN
module aes_spi_responder
  import aes_spi_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 256,
  parameter int OP_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  output logic [KEY_W-1:0]   key_out,
  output logic [7:0]         Nk_out,
  output logic [BLOCK_W-1:0] data_out,
  input  logic [BLOCK_W-1:0] result_in,
  input  logic               keyExpansionDone,
  input  logic               encryptionDone,
  input  logic               decryptionDone,
  output logic               resetKeyExpansion,
  output logic               resetCipher,
  output logic               resetDecipher,
  output logic               busy
);

  stateT              state;
  cmdT                cmd;
  logic [8:0]         payLen;
  logic [8:0]         respLen;
  logic               keyValid;
  logic               resultValid;
  logic               err;
  logic [BLOCK_W-1:0] result;

  logic               clear, shiftIn, shiftOut, loadOut, clearOut;
  logic [OUT_W-1:0]   outData;
  logic [8:0]         count;
  logic [255:0]       shiftedNow;
  logic [OP_W-1:0]    opNow;
  logic [7:0]         statusByte;
  logic               doneSel;

  aes_spi_shifter shifter (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .shiftIn    (shiftIn),
    .inBit      (mosi),
    .shiftOut   (shiftOut),
    .loadOut    (loadOut),
    .clearOut   (clearOut),
    .outData    (outData),
    .count      (count),
    .shiftedNow (shiftedNow),
    .outBit     (miso)
  );

  assign opNow = shiftedNow[OP_W-1:0];

`ifdef AES_RSP_STATUS_EN
  assign statusByte = {busy, keyValid, resultValid, err, Nk_out[3:0]};
`else
  assign statusByte = 8'h00;
`endif

  always_comb begin
    case (cmd)
      CMD_KEY: doneSel = keyExpansionDone;
      CMD_ENC: doneSel = encryptionDone;
      default: doneSel = decryptionDone;
    endcase
  end

  // Shifter strobes act in the same cycle as the bit being sampled.
  always_comb begin
    clear    = 1'b0;
    shiftIn  = 1'b0;
    shiftOut = 1'b0;
    loadOut  = 1'b0;
    clearOut = 1'b0;
    outData  = {(resultValid ? result : {BLOCK_W{1'b0}}), statusByte};
    case (state)
      IDLE: shiftIn = cs;
      OPCODE: begin
        if (!cs) clear = 1'b1;
        else begin
          shiftIn = 1'b1;
          if (count == 9'(OP_W - 1)) begin
            clear = 1'b1;
            if (opNow == OP_READ) loadOut = 1'b1;
`ifdef AES_RSP_STATUS_EN
            if (opNow == OP_STATUS) begin
              loadOut = 1'b1;
              outData = {statusByte, {BLOCK_W{1'b0}}};
            end
`endif
          end
        end
      end
      PAYLOAD: begin
        if (!cs) clear = 1'b1;
        else begin
          shiftIn = 1'b1;
          if (count == payLen - 9'd1) clear = 1'b1;
        end
      end
      RESPOND: begin
        if (!cs) begin
          clear    = 1'b1;
          clearOut = 1'b1;
        end else begin
          shiftOut = 1'b1;
          if (count == respLen - 9'd1) clear = 1'b1;
        end
      end
      default: begin
        clear    = 1'b1;
        clearOut = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cmd               <= CMD_KEY;
      payLen            <= LEN_BLOCK;
      respLen           <= LEN_READ;
      keyValid          <= 1'b0;
      resultValid       <= 1'b0;
      err               <= 1'b0;
      result            <= '0;
      key_out           <= '0;
      Nk_out            <= 8'd4;
      data_out          <= '0;
      resetKeyExpansion <= 1'b1;
      resetCipher       <= 1'b1;
      resetDecipher     <= 1'b1;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cs) state <= OPCODE;
        OPCODE: begin
          if (!cs) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (count == 9'(OP_W - 1)) begin
            case (opNow)
              OP_KEY128, OP_KEY192, OP_KEY256: begin
                if (busy) begin
                  err   <= 1'b1;
                  state <= DRAIN;
                end else begin
                  cmd      <= CMD_KEY;
                  keyValid <= 1'b0;
                  payLen   <= (opNow == OP_KEY128) ? LEN_KEY128 :
                              (opNow == OP_KEY192) ? LEN_KEY192 : LEN_KEY256;
                  state    <= PAYLOAD;
                end
              end
              OP_ENC, OP_DEC: begin
                if (busy || !keyValid) begin
                  err   <= 1'b1;
                  state <= DRAIN;
                end else begin
                  cmd    <= (opNow == OP_ENC) ? CMD_ENC : CMD_DEC;
                  payLen <= LEN_BLOCK;
                  state  <= PAYLOAD;
                end
              end
              OP_READ: begin
                err     <= !resultValid;
                respLen <= LEN_READ;
                state   <= RESPOND;
              end
`ifdef AES_RSP_STATUS_EN
              OP_STATUS: begin
                respLen <= LEN_STATUS;
                state   <= RESPOND;
              end
`endif
              default: begin
                err   <= 1'b1;
                state <= DRAIN;
              end
            endcase
          end
        end
        PAYLOAD: begin
          if (!cs) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (count == payLen - 9'd1) begin
            case (cmd)
              CMD_KEY: begin
                key_out           <= leftAlignKey(shiftedNow, payLen);
                Nk_out            <= {4'd0, payLen[8:5]};
                resetKeyExpansion <= 1'b0;
              end
              CMD_ENC: begin
                data_out    <= shiftedNow[BLOCK_W-1:0];
                resetCipher <= 1'b0;
              end
              default: begin
                data_out      <= shiftedNow[BLOCK_W-1:0];
                resetDecipher <= 1'b0;
              end
            endcase
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // cs is deliberately ignored here: a started core always runs to completion.
          if (doneSel) begin
            if (cmd == CMD_KEY) keyValid <= 1'b1;
            else begin
              result      <= result_in;
              resultValid <= 1'b1;
            end
            resetKeyExpansion <= 1'b1;
            resetCipher       <= 1'b1;
            resetDecipher     <= 1'b1;
            busy              <= 1'b0;
            state             <= cs ? DRAIN : IDLE;
          end
        end
        RESPOND: begin
          if (!cs) state <= IDLE;
          else if (count == respLen - 9'd1) state <= DRAIN;
        end
        DRAIN: if (!cs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_responder.sv
// tb/tb_aes_spi_responder.sv - directed self-checking bench for aes_spi_responder
module tb_aes_spi_responder;
  import aes_spi_pkg::*;

  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset, cs, mosi, miso;
  logic [255:0] key_out;
  logic [7:0]   Nk_out;
  logic [127:0] data_out, result_in;
  logic         keyExpansionDone, encryptionDone, decryptionDone;
  logic         resetKeyExpansion, resetCipher, resetDecipher, busy;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes_spi_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso),
    .key_out(key_out), .Nk_out(Nk_out), .data_out(data_out), .result_in(result_in),
    .keyExpansionDone(keyExpansionDone), .encryptionDone(encryptionDone),
    .decryptionDone(decryptionDone), .resetKeyExpansion(resetKeyExpansion),
    .resetCipher(resetCipher), .resetDecipher(resetDecipher), .busy(busy)
  );

  function automatic logic coreHold(input int which);
    case (which)
      0:       return resetKeyExpansion;
      1:       return resetCipher;
      default: return resetDecipher;
    endcase
  endfunction

  task automatic setDone(input int which, input logic v);
    case (which)
      0:       keyExpansionDone = v;
      1:       encryptionDone   = v;
      default: decryptionDone   = v;
    endcase
  endtask

  task automatic sendBits(input logic [255:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      cs   = 1'b1;
      mosi = v[i];
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits({248'h0, b}, 8);
  endtask

  task automatic doReset;
    @(negedge clk);
    reset = 1'b1; cs = 1'b0; mosi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered on the negedge after the last payload bit; other dones are raised to prove they are ignored.
  task automatic runCore(input int which, input logic [127:0] res);
    bit heldLow = 1'b1;
    int n = 0;
    for (int w = 0; w < 3; w++) if (w != which) setDone(w, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (coreHold(which) !== 1'b0 || busy !== 1'b1) heldLow = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!heldLow) begin errors++; $display("FAIL core_hold_low core=%0d not held low/busy until done", which); end
    for (int w = 0; w < 3; w++) setDone(w, 1'b0);
    result_in = res;
    setDone(which, 1'b1);
    do begin @(negedge clk); n++; end while (coreHold(which) !== 1'b1 && n < 20);
    checks++;
    if (n != 1) begin errors++; $display("FAIL core_release_latency core=%0d got %0d cycles exp 1", which, n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b exp 0", busy); end
    setDone(which, 1'b0);
    result_in = '0;
  endtask

  task automatic loadKey(input logic [7:0] op, input logic [255:0] key, input int n, input logic [255:0] expKey,
                         input logic [7:0] expNk);
    sendByte(op);
    sendBits(key, n);
    @(negedge clk);
    checks++;
    if (key_out !== expKey) begin errors++; $display("FAIL key_out got %h exp %h", key_out, expKey); end
    checks++;
    if (Nk_out !== expNk) begin errors++; $display("FAIL Nk_out got %0d exp %0d", Nk_out, expNk); end
    cs = 1'b0; mosi = 1'b0;
    runCore(0, 128'h0);
    checks++;
    if (dut.keyValid !== 1'b1) begin errors++; $display("FAIL key_valid_set got %b exp 1", dut.keyValid); end
  endtask

  task automatic readResp(output logic [127:0] got);
    got = '0;
    sendByte(OP_READ);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      mosi = 1'b0;
      got  = {got[126:0], miso};
    end
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic test_reset;
    doReset();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (key_out !== '0 || data_out !== '0) begin errors++; $display("FAIL reset_regs key %h data %h exp 0", key_out, data_out); end
    checks++; if (Nk_out !== 8'd4) begin errors++; $display("FAIL reset_nk got %0d exp 4", Nk_out); end
    checks++;
    if ({resetKeyExpansion, resetCipher, resetDecipher} !== 3'b111) begin
      errors++; $display("FAIL reset_holds got %b exp 111", {resetKeyExpansion, resetCipher, resetDecipher});
    end
    checks++;
    if ({dut.keyValid, dut.resultValid, dut.err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {dut.keyValid, dut.resultValid, dut.err});
    end
  endtask

  task automatic test_no_key;
    logic [127:0] got;
    doReset();
    sendByte(OP_ENC);
    @(negedge clk);
    checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL nokey_drain got %0d exp %0d", dut.state, DRAIN); end
    checks++; if (dut.err !== 1'b1) begin errors++; $display("FAIL nokey_err got %b exp 1", dut.err); end
    sendBits({128'h0, PT}, 128);
    @(negedge clk);
    checks++; if (resetCipher !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nokey_idle rc %b busy %b exp 1 0", resetCipher, busy); end
    cs = 1'b0;
    readResp(got);
    checks++; if (got !== '0) begin errors++; $display("FAIL nokey_read got %h exp 0", got); end
    checks++; if (dut.err !== 1'b1) begin errors++; $display("FAIL nokey_read_err got %b exp 1", dut.err); end
  endtask

  task automatic test_cs_abort;
    doReset();
    loadKey(OP_KEY128, {128'h0, KEY128}, 128, {KEY128, 128'h0}, 8'd4);
    sendByte(OP_ENC);
    sendBits({196'h0, PT[127:68]}, 60);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL abort_idle got %0d exp %0d", dut.state, IDLE); end
    checks++; if (dut.err !== 1'b1) begin errors++; $display("FAIL abort_err got %b exp 1", dut.err); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL abort_data got %h exp 0", data_out); end
    checks++; if (resetCipher !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_core rc %b busy %b exp 1 0", resetCipher, busy); end
  endtask

  task automatic test_key256_encrypt;
    logic [127:0] got;
    loadKey(OP_KEY256, KEY256, 256, KEY256, 8'd8);
    sendByte(OP_ENC);
    sendBits({128'h0, PT}, 128);
    @(negedge clk);
    checks++; if (data_out !== PT) begin errors++; $display("FAIL enc_data_out got %h exp %h", data_out, PT); end
    cs = 1'b0;
    runCore(1, CT256);
    readResp(got);
    checks++; if (got !== CT256) begin errors++; $display("FAIL enc_read got %h exp %h", got, CT256); end
    checks++; if (dut.err !== 1'b0) begin errors++; $display("FAIL enc_read_err got %b exp 0", dut.err); end
  endtask

  task automatic test_key128_decrypt;
    logic [127:0] got;
    loadKey(OP_KEY128, {128'h0, KEY128}, 128, {KEY128, 128'h0}, 8'd4);
    sendByte(OP_DEC);
    sendBits({128'h0, CT128}, 128);
    @(negedge clk);
    checks++; if (data_out !== CT128) begin errors++; $display("FAIL dec_data_out got %h exp %h", data_out, CT128); end
    cs = 1'b0;
    runCore(2, PT);
    readResp(got);
    checks++; if (got !== PT) begin errors++; $display("FAIL dec_read got %h exp %h", got, PT); end
    checks++; if (Nk_out !== 8'd4) begin errors++; $display("FAIL dec_nk got %0d exp 4", Nk_out); end
  endtask

  task automatic test_bad_opcode;
    logic [127:0] got;
    bit misoQuiet = 1'b1;
    sendByte(8'h7F);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (miso !== 1'b0) misoQuiet = 1'b0;
      mosi = (i % 3 == 0);
    end
    @(negedge clk);
    checks++; if (!misoQuiet) begin errors++; $display("FAIL drain_miso got nonzero exp 0"); end
    checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL drain_state got %0d exp %0d", dut.state, DRAIN); end
    checks++; if (dut.err !== 1'b1) begin errors++; $display("FAIL drain_err got %b exp 1", dut.err); end
    cs = 1'b0;
    readResp(got);
    checks++; if (got !== PT) begin errors++; $display("FAIL drain_read got %h exp %h", got, PT); end
    checks++; if (dut.err !== 1'b0) begin errors++; $display("FAIL read_clears_err got %b exp 0", dut.err); end
  endtask

  task automatic test_reset_mid_run;
    loadKey(OP_KEY128, {128'h0, KEY128}, 128, {KEY128, 128'h0}, 8'd4);
    sendByte(OP_DEC);
    sendBits({128'h0, CT128}, 128);
    @(negedge clk);
    checks++; if (resetDecipher !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrun_started rd %b busy %b exp 0 1", resetDecipher, busy); end
    cs = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (resetDecipher !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset rd %b busy %b exp 1 0", resetDecipher, busy); end
    checks++;
    if (dut.resultValid !== 1'b0 || dut.keyValid !== 1'b0) begin
      errors++; $display("FAIL midrun_flags rv %b kv %b exp 0 0", dut.resultValid, dut.keyValid);
    end
`ifdef AES_RSP_STATUS_EN
    begin
      logic [7:0] st = '0;
      sendByte(OP_STATUS);
      for (int i = 0; i < 8; i++) begin @(negedge clk); mosi = 1'b0; st = {st[6:0], miso}; end
      @(negedge clk);
      cs = 1'b0;
      checks++; if (st !== 8'h04) begin errors++; $display("FAIL status_byte got %h exp 04", st); end
    end
`endif
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; mosi = 1'b0; result_in = '0;
    keyExpansionDone = 1'b0; encryptionDone = 1'b0; decryptionDone = 1'b0;
    test_reset();
    test_no_key();
    test_cs_abort();
    test_key256_encrypt();
    test_key128_decrypt();
    test_bad_opcode();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
